dmem_lsu: RTL

Parametrised data memory with a built-in load/store unit. Successor to the single-cycle data memory, for the pipelined core.
- Accepts one RV32 load/store per request over a valid/ready handshake.
- Stores: shifts store data into byte lanes and derives the byte mask from funct3 and the address.
- Loads: returns sign- or zero-extended data after a configurable synchronous read latency.
- Sits between the MEM stage and the word-organised byte-lane memory array.

---
 rtl/dmem_lsu_if.sv | 27 ++
 rtl/dmem_lsu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between the MEM stage (master)
// and the data memory load/store unit (slave).
interface dmem_lsu_if #(
  parameter int DMEM_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [DMEM_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Pipeline side: issues requests, consumes responses
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised byte-lane data memory with an RV32 load/store
// unit in front of it. Stores are lane-shifted and masked, loads are
// extended and returned RD_LAT cycles after accept.
// Optional feature macro: DMEM_ERR_EN enables misalignment and illegal
// funct3 detection; without it addresses are force-aligned and rsp_err is 0.
module dmem_lsu #(
  parameter int DMEM_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);

  localparam int         Depth   = 2 ** (DMEM_W - 2);
  localparam logic [1:0] CntInit = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        rspValid_q;
  logic        rspErr_q;
  logic [31:0] rspData_q;
  logic        holdErr_q;
  logic [31:0] holdData_q;

  logic [3:0][7:0] mem_q [Depth];

  logic              accept;
  logic              memWrite;
  logic              accErr;
  logic [DMEM_W-3:0] wordIdx;
  logic [1:0]        sizeSel;
  logic [1:0]        laneOff;
  logic [31:0]       rawWord;
  logic [31:0]       shifted;
  logic [31:0]       loadData_d;
  logic [31:0]       result_d;
  logic [3:0]        byteMask;
  logic [31:0]       laneData;

  // Ready is withheld during reset and while a multi-cycle read is pending
  assign bus.req_ready = !rst && (state_q != WAIT);
  assign accept        = bus.req_valid && bus.req_ready;
  assign wordIdx       = bus.req_addr[DMEM_W-1:2];

  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspData_q;
  assign bus.rsp_err   = rspErr_q;

  // Access size from funct3: 0 byte, 1 half, 2 word (illegal codes act as word)
  always_comb begin
    sizeSel = 2'd2;
    case (bus.req_funct3)
      3'd0, 3'd4: sizeSel = 2'd0;
      3'd1, 3'd5: sizeSel = 2'd1;
      default:    sizeSel = 2'd2;
    endcase
  end

  // Lane offset, force-aligned to the access size
  always_comb begin
    laneOff = 2'd0;
    case (sizeSel)
      2'd0:    laneOff = bus.req_addr[1:0];
      2'd1:    laneOff = {bus.req_addr[1], 1'b0};
      default: laneOff = 2'd0;
    endcase
  end

`ifdef DMEM_ERR_EN
  // Flag misaligned halves/words and funct3 codes that are not legal here
  always_comb begin
    accErr = 1'b0;
    case (bus.req_funct3)
      3'd0:    accErr = 1'b0;
      3'd1:    accErr = bus.req_addr[0];
      3'd2:    accErr = (bus.req_addr[1:0] != 2'b00);
      3'd4:    accErr = bus.req_we;
      3'd5:    accErr = bus.req_we | bus.req_addr[0];
      default: accErr = 1'b1;
    endcase
  end
`else
  assign accErr = 1'b0;
`endif

  // Load path: pick the addressed lanes and sign/zero-extend them
  always_comb begin
    rawWord    = mem_q[wordIdx];
    shifted    = rawWord >> {laneOff, 3'b000};
    loadData_d = shifted;
    case (bus.req_funct3)
      3'd0:    loadData_d = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    loadData_d = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    loadData_d = {24'd0, shifted[7:0]};
      3'd5:    loadData_d = {16'd0, shifted[15:0]};
      default: loadData_d = shifted;
    endcase
    result_d = (bus.req_we || accErr) ? 32'd0 : loadData_d;
  end

  // Store path: replicate data across lanes and build the byte mask
  always_comb begin
    byteMask = 4'hF;
    laneData = bus.req_wdata;
    case (sizeSel)
      2'd0: begin
        byteMask = 4'b0001 << laneOff;
        laneData = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        byteMask = 4'b0011 << laneOff;
        laneData = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        byteMask = 4'hF;
        laneData = bus.req_wdata;
      end
    endcase
    memWrite = accept && bus.req_we && !accErr;
  end

  // Byte-lane memory array, written on the accept edge (contents never reset)
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteMask[i]) begin
          mem_q[wordIdx][i] <= laneData[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered response outputs that idle at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      rspValid_q <= 1'b0;
      rspData_q  <= 32'd0;
      rspErr_q   <= 1'b0;
      holdData_q <= 32'd0;
      holdErr_q  <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      rspData_q  <= 32'd0;
      rspErr_q   <= 1'b0;
      case (state_q)
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspData_q  <= holdData_q;
            rspErr_q   <= holdErr_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          if (accept) begin
            if (RD_LAT == 1) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspData_q  <= result_d;
              rspErr_q   <= accErr;
            end else begin
              state_q    <= WAIT;
              cnt_q      <= CntInit;
              holdData_q <= result_d;
              holdErr_q  <= accErr;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
